uart_bus_ctrl: RTL
==================

Name: uart_bus_ctrl

Overview:
- Memory-mapped UART slave on the CPU data bus; sits directly downstream of the single-cycle CPU's load/store path.
- Decodes ALU-produced addresses plus MemRd/MemWr. Serialises bytes to the TX pin and deserialises the RX pin.
- ReadData is zero when not selected, so it can be ORed with the data-memory and peripheral read buses.
- Drives the RX and TX interrupt lines to the interrupt logic.

Parameters:
- CLK_DIV, 2604, clk cycles per bit (25 MHz / 9600 baud); legal range 4..65535.
- BASE_ADDR, 32'h40000018, address of the TXD register; RXD is at BASE+4, CON at BASE+8.

Ports:
- clk  input  1  CPU clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- MemRd  input  1  bus read strobe.
- MemWr  input  1  bus write strobe.
- Addr  input  32  byte address from the ALU output.
- WriteData  input  32  store data (register-file port B).
- ReadData  output  32  combinational read data; 0 when not selected.
- UART_RX  input  1  serial in, asynchronous to clk, idle high.
- UART_TX  output  1  serial out, idle high.
- IRQ_RX  output  1  receive interrupt, level.
- IRQ_TX  output  1  transmit-done interrupt, level.

Behaviour:
Reset (async, reset==0):
- UART_TX=1; IRQ_RX=0; IRQ_TX=0.
- All flags, data registers and enables 0; both FSMs IDLE.
- Reset mid-frame aborts the frame; UART_TX returns high immediately.

Register map (only Addr[31:0] equal to an exact word address selects a register):
- TXD: write [7:0] = tx byte; read returns {24'b0, last written byte}.
- RXD: read returns {24'b0, rx_data}.
- CON bits:
  - [0] tx_ie, R/W.
  - [1] rx_ie, R/W.
  - [2] tx_done, RO, cleared by read of CON.
  - [3] rx_valid, RO.
  - [4] tx_busy, RO.
  - [5] rx_overrun, RO, cleared by read of CON.
  - [6] frame_err, RO, cleared by read of CON.
  - [31:7] read 0.
- Writes to CON affect only bits [1:0].

Bus timing:
- ReadData is combinational from Addr/MemRd in the same cycle.
- Writes and read side-effects (flag clears) take effect at the posedge where the strobe is high.

IRQs:
- IRQ_RX = rx_ie & rx_valid.
- IRQ_TX = tx_ie & tx_done.

TX FSM (IDLE, START, DATA, STOP):
- A TXD write with tx_busy==0 at that edge latches the byte, sets tx_busy and enters START.
- A TXD write with tx_busy==1 is ignored: tx byte unchanged, no error flag.
- START drives 0 for CLK_DIV cycles.
- DATA drives bits 0..7, LSB first, CLK_DIV cycles each; 3-bit index.
- STOP drives 1 for CLK_DIV cycles.
- On the last STOP cycle: tx_busy clears and tx_done sets at the same edge; FSM returns to IDLE.
- Frame length is exactly 10*CLK_DIV cycles from the write edge to tx_busy=0.
- A new write is accepted in the cycle after busy clears.

RX FSM (IDLE, START, DATA, STOP):
- UART_RX passes through a 2-flop synchroniser; a falling edge of the synchronised value in IDLE enters START.
- START waits CLK_DIV/2 cycles, then samples:
  - 1: glitch, return to IDLE; no flag change.
  - 0: enter DATA.
- DATA samples 8 bits, each CLK_DIV cycles after the previous sample, LSB first.
- STOP samples once CLK_DIV later:
  - 1: rx_data <= shifted byte, rx_valid <= 1. If rx_valid was already 1, also set rx_overrun; new data overwrites old.
  - 0: frame_err <= 1; rx_data and rx_valid unchanged.
- After the stop sample, return to IDLE; ready for the next falling edge immediately.
- A read of RXD clears rx_valid.

Simultaneous events:
- Set wins over clear. An RX completion in the same cycle as an RXD read leaves rx_valid=1; ReadData in that cycle shows the old byte.
- tx_done set in the same cycle as a CON read leaves tx_done=1.
- MemRd and MemWr both high: the write occurs; ReadData still shows the pre-write value.
- The baud counters are independent; TX and RX run full-duplex.

Test Plan:
- Reset then idle: CLK_DIV=4; hold reset=0 → UART_TX=1, IRQs 0, CON read = 0.
- TX frame: write TXD=0xA5, CON=1 → UART_TX sequence 0,1,0,1,0,0,1,0,1,1, 4 cycles each. tx_busy=1 for 40 cycles, then tx_done=1 and IRQ_TX=1. CON read returns 0x05; the next CON read returns 0x01 and IRQ_TX=0.
- Busy rejection: write 0x3C, then write 0xFF 5 cycles later → line carries 0x3C only; TXD read = 0x3C.
- RX byte: CON=2; drive 0x5A frame at 4 cycles/bit → rx_valid=1, IRQ_RX=1, RXD read = 0x5A. The next cycle shows rx_valid=0.
- Overrun and framing error:
  - Receive 0x11 then 0x22 without reading → RXD = 0x22, CON bit5=1.
  - Next frame with stop=0 → CON bit6=1, RXD still 0x22.
  - 1-cycle low glitch on UART_RX → no flag change.
- Reset mid-TX: assert reset during DATA bit 3 → UART_TX=1 asynchronously. After release, a new write transmits a full correct frame.

Source files
------------

// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl: memory-mapped UART slave on the CPU data bus (TXD @BASE, RXD @BASE+4, CON @BASE+8).
// Latency: ReadData is combinational; writes/flag clears land on the strobe edge; TX frame = 10*CLK_DIV cycles.
// Backpressure: none on the bus; a TXD write while tx_busy is dropped silently, RX overwrite flags rx_overrun.
// Ports: clk/reset (async active-low); MemRd/MemWr/Addr/WriteData/ReadData bus slave;
//        UART_RX/UART_TX serial pins; IRQ_RX/IRQ_TX level interrupts.
module uart_bus_ctrl #(
  parameter int unsigned CLK_DIV   = 2604,           // clk cycles per bit, 4..65535
  parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic        UART_RX,
  output logic        UART_TX,
  output logic        IRQ_RX,
  output logic        IRQ_TX
);

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bus decode: exact word addresses only
  logic sel_txd, sel_rxd, sel_con;
  logic wr_txd, wr_con, rd_rxd, rd_con;
  assign sel_txd = (Addr == BASE_ADDR);
  assign sel_rxd = (Addr == BASE_ADDR + 32'd4);
  assign sel_con = (Addr == BASE_ADDR + 32'd8);
  assign wr_txd  = MemWr & sel_txd;
  assign wr_con  = MemWr & sel_con;
  assign rd_rxd  = MemRd & sel_rxd;
  assign rd_con  = MemRd & sel_con;

  logic unused_wdata;
  assign unused_wdata = ^WriteData[31:8];

  // TX path
  state_t      tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_idx_q;
  logic [7:0]  tx_byte_q;
  logic        tx_line_q;
  logic        tx_busy;
  logic        tx_done_set;

  assign tx_busy     = (tx_state_q != S_IDLE);
  assign tx_done_set = (tx_state_q == S_STOP) && (tx_cnt_q == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_byte_q  <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          if (wr_txd) begin
            tx_byte_q  <= WriteData[7:0];
            tx_line_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_state_q <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_q == DIV_LAST) begin
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_line_q  <= tx_byte_q[0];
            tx_state_q <= S_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (tx_cnt_q == DIV_LAST) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == 3'd7) begin
              tx_line_q  <= 1'b1;
              tx_state_q <= S_STOP;
            end else begin
              tx_idx_q  <= tx_idx_q + 3'd1;
              tx_line_q <= tx_byte_q[tx_idx_q + 3'd1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (tx_cnt_q == DIV_LAST) begin
            tx_cnt_q   <= '0;
            tx_state_q <= S_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  // RX path: synchroniser flops reset high so release of reset never looks like a start bit
  state_t      rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_idx_q;
  logic [7:0]  rx_shift_q;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_ok_set, rx_bad_set;

  assign rx_ok_set  = (rx_state_q == S_STOP) && (rx_cnt_q == DIV_LAST) &&  rx_s2_q;
  assign rx_bad_set = (rx_state_q == S_STOP) && (rx_cnt_q == DIV_LAST) && !rx_s2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_s1_q   <= UART_RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      case (rx_state_q)
        S_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= S_START;
          end
        end
        S_START: begin
          // half-bit wait puts every later sample near the bit centre
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (rx_cnt_q == DIV_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            if (rx_idx_q == 3'd7) rx_state_q <= S_STOP;
            else                  rx_idx_q   <= rx_idx_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (rx_cnt_q == DIV_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= S_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // Status/control registers; a set in the same cycle as a read-clear wins
  logic [7:0] rx_data_q;
  logic       rx_valid_q, rx_ovr_q, frame_err_q, tx_done_q;
  logic       tx_ie_q, rx_ie_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_ie_q     <= 1'b0;
      rx_ie_q     <= 1'b0;
    end else begin
      if (rx_ok_set) rx_data_q <= rx_shift_q;
      rx_valid_q  <= rx_ok_set | (rx_valid_q & ~rd_rxd);
      rx_ovr_q    <= (rx_ok_set & rx_valid_q) | (rx_ovr_q & ~rd_con);
      frame_err_q <= rx_bad_set | (frame_err_q & ~rd_con);
      tx_done_q   <= tx_done_set | (tx_done_q & ~rd_con);
      if (wr_con) begin
        tx_ie_q <= WriteData[0];
        rx_ie_q <= WriteData[1];
      end
    end
  end

  always_comb begin
    ReadData = '0;
    if (MemRd) begin
      if (sel_txd)      ReadData = {24'b0, tx_byte_q};
      else if (sel_rxd) ReadData = {24'b0, rx_data_q};
      else if (sel_con) ReadData = {25'b0, frame_err_q, rx_ovr_q, tx_busy,
                                    rx_valid_q, tx_done_q, rx_ie_q, tx_ie_q};
    end
  end

  assign UART_TX = tx_line_q;
  assign IRQ_RX  = rx_ie_q & rx_valid_q;
  assign IRQ_TX  = tx_ie_q & tx_done_q;

endmodule
